// File: rtl/act_readback_ctrl.sv
// Activation readback controller: issues PE/address read requests to the
// accelerator, buffers indexed responses in a FWFT FIFO and streams them out.
module act_readback_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] act_no,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        read_en,
  input  logic        read_rdy,
  output logic [15:0] read_addr,
  output logic        read_data_rdy,
  input  logic        read_data_vld,
  input  logic [31:0] read_data,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [11:0] out_idx,
  output logic [15:0] out_act
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [11:0] DEPTH12 = 12'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e      state_q, state_d;
  logic [11:0] act_no_q, act_no_d;
  logic [11:0] issued_q, issued_d;
  logic [11:0] received_q, received_d;
  logic [11:0] popped_q, popped_d;
  logic [5:0]  pe_idx_q, pe_idx_d;
  logic [5:0]  act_addr_q, act_addr_d;
  logic        err_q, err_d;
  logic        live_q, live_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [27:0] mem_q [FIFO_DEPTH];

  logic        fifo_empty, fifo_full;
  logic        xfer, accept, push, pop;
  logic [11:0] outstanding;
  logic        unused_bits;

  always_comb begin
    fifo_empty  = (wr_ptr_q == rd_ptr_q);
    fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    outstanding = issued_q - popped_q;
    unused_bits = ^read_data[31:28];

    busy          = (state_q != IDLE);
    done          = (state_q == DONE);
    err           = err_q;
    read_en       = (state_q == ISSUE) && (issued_q < act_no_q) &&
                    (outstanding < DEPTH12);
    read_addr     = {pe_idx_q, 4'b0000, act_addr_q};
    // live_q holds the response port closed for the cycle after reset
    read_data_rdy = live_q && !fifo_full;
    out_vld       = !fifo_empty;
    out_idx       = mem_q[rd_ptr_q[AW-1:0]][27:16];
    out_act       = mem_q[rd_ptr_q[AW-1:0]][15:0];

    xfer   = read_en && read_rdy;
    accept = read_data_vld && read_data_rdy;
    // responses accepted while idle are stale and silently dropped
    push   = accept && ((state_q == ISSUE) || (state_q == DRAIN));
    pop    = out_vld && out_rdy;
  end

  always_comb begin
    state_d    = state_q;
    act_no_d   = act_no_q;
    issued_d   = issued_q;
    received_d = received_q;
    popped_d   = popped_q;
    pe_idx_d   = pe_idx_q;
    act_addr_d = act_addr_q;
    err_d      = err_q;
    live_d     = 1'b1;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          act_no_d   = act_no;
          issued_d   = '0;
          received_d = '0;
          popped_d   = '0;
          pe_idx_d   = '0;
          act_addr_d = '0;
          err_d      = 1'b0;
          state_d    = (act_no == 12'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (xfer) begin
          issued_d = issued_q + 12'd1;
          if (pe_idx_q == 6'd63) begin
            pe_idx_d   = '0;
            act_addr_d = act_addr_q + 6'd1;
          end else begin
            pe_idx_d = pe_idx_q + 6'd1;
          end
          if (issued_q + 12'd1 == act_no_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (popped_q == act_no_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) begin
      received_d = received_q + 12'd1;
      wr_ptr_d   = wr_ptr_q + 1'b1;
      if (read_data[27:16] != received_q) err_d = 1'b1;
    end
    if (pop) begin
      popped_d = popped_q + 12'd1;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      act_no_q   <= '0;
      issued_q   <= '0;
      received_q <= '0;
      popped_q   <= '0;
      pe_idx_q   <= '0;
      act_addr_q <= '0;
      err_q      <= 1'b0;
      live_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      act_no_q   <= act_no_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      popped_q   <= popped_d;
      pe_idx_q   <= pe_idx_d;
      act_addr_q <= act_addr_d;
      err_q      <= err_d;
      live_q     <= live_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= read_data[27:0];
  end

endmodule

// File: tb/tb_act_readback_ctrl.sv
// Scoreboard bench for act_readback_ctrl: a bench-side accelerator model
// answers requests; a negedge monitor checks addresses and the output stream.
module tb_act_readback_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, read_rdy, read_data_vld, out_rdy;
  logic [11:0] act_no;
  logic [31:0] read_data;
  logic        busy, done, err, read_en, read_data_rdy, out_vld;
  logic [15:0] read_addr, out_act;
  logic [11:0] out_idx;

  always #5 clk = ~clk;

  act_readback_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .act_no(act_no),
    .busy(busy), .done(done), .err(err),
    .read_en(read_en), .read_rdy(read_rdy), .read_addr(read_addr),
    .read_data_rdy(read_data_rdy), .read_data_vld(read_data_vld),
    .read_data(read_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_idx(out_idx), .out_act(out_act)
  );

  typedef struct {int due; logic [31:0] data;} rsp_t;

  rsp_t        pend[$];
  logic [15:0] exp_addr[$];
  logic [27:0] exp_out[$];
  int checks = 0, errors = 0;
  int cyc = 0, req_cnt = 0, done_cnt = 0, bad_pos = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [15:0] val(input int k);
    return 16'hA5A5 ^ (16'(k) * 16'h0123);
  endfunction

  // accelerator response driver: presents the oldest due response
  initial begin
    read_data_vld = 1'b0;
    read_data     = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        read_data_vld = 1'b1;
        read_data     = pend[0].data;
      end else begin
        read_data_vld = 1'b0;
        read_data     = '0;
      end
    end
  end

  // monitor: evaluates the handshakes that the coming rising edge will take
  initial begin
    logic [11:0] idx;
    logic [27:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (done) done_cnt++;
        if (read_en && read_rdy) begin
          if (exp_addr.size() == 0) note_fail("req_unexpected");
          else chk("req_addr", {16'h0, read_addr}, {16'h0, exp_addr.pop_front()});
          idx = (req_cnt == bad_pos) ? 12'd5 : 12'(req_cnt);
          pend.push_back('{cyc + 2, {4'hF, idx, val(req_cnt)}});
          req_cnt++;
        end
        if (read_data_vld && read_data_rdy) void'(pend.pop_front());
        if (out_vld && out_rdy) begin
          if (exp_out.size() == 0) note_fail("out_unexpected");
          else begin
            e = exp_out.pop_front();
            chk("out_idx", {20'h0, out_idx}, {20'h0, e[27:16]});
            chk("out_act", {16'h0, out_act}, {16'h0, e[15:0]});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n, input int bad);
    req_cnt  = 0;
    done_cnt = 0;
    bad_pos  = bad;
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back({6'(k), 4'b0000, 6'(k >> 6)});
      exp_out.push_back({((k == bad) ? 12'd5 : 12'(k)), val(k)});
    end
    act_no = 12'(n);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 500) begin
      tick();
      n++;
    end
    chk(name, {31'h0, done}, 32'd1);
  endtask

  task automatic end_run(input string name);
    tick();
    tick();
    chk({name, "_done_cnt"}, done_cnt, 32'd1);
    chk({name, "_out_left"}, exp_out.size(), 32'd0);
    chk({name, "_addr_left"}, exp_addr.size(), 32'd0);
    chk({name, "_busy"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; start = 1'b0; act_no = '0; read_rdy = 1'b1; out_rdy = 1'b1;
    tick();
    tick();
    chk("rst_busy",  {31'h0, busy}, 32'd0);
    chk("rst_done",  {31'h0, done}, 32'd0);
    chk("rst_err",   {31'h0, err}, 32'd0);
    chk("rst_rd_en", {31'h0, read_en}, 32'd0);
    chk("rst_rdrdy", {31'h0, read_data_rdy}, 32'd0);
    chk("rst_oval",  {31'h0, out_vld}, 32'd0);
    chk("rst_addr",  {16'h0, read_addr}, 32'd0);
    rst = 1'b1;
    tick();

    // three activations, two-cycle responses
    start_run(3, -1);
    wait_done("t3_done");
    chk("t3_err", {31'h0, err}, 32'd0);
    end_run("t3");

    // act_addr advances after pe_idx wraps
    start_run(66, -1);
    wait_done("t66_done");
    chk("t66_err", {31'h0, err}, 32'd0);
    end_run("t66");

    // backpressure limits outstanding reads to the FIFO depth
    out_rdy = 1'b0;
    start_run(10, -1);
    repeat (20) tick();
    chk("bp_req_cnt", req_cnt, 32'd4);
    chk("bp_read_en", {31'h0, read_en}, 32'd0);
    chk("bp_out_vld", {31'h0, out_vld}, 32'd1);
    chk("bp_rdrdy",   {31'h0, read_data_rdy}, 32'd0);
    out_rdy = 1'b1;
    wait_done("bp_done");
    chk("bp_req_total", req_cnt, 32'd10);
    end_run("bp");

    // wrong index on the third response
    start_run(5, 2);
    wait_done("bad_done");
    chk("bad_err_at_done", {31'h0, err}, 32'd1);
    end_run("bad");
    chk("bad_err_held", {31'h0, err}, 32'd1);

    // zero-length readback; also clears err
    start_run(0, -1);
    chk("zero_done", {31'h0, done}, 32'd1);
    chk("zero_busy", {31'h0, busy}, 32'd1);
    chk("zero_err",  {31'h0, err}, 32'd0);
    tick();
    chk("zero_busy_off", {31'h0, busy}, 32'd0);
    chk("zero_done_off", {31'h0, done}, 32'd0);
    chk("zero_reqs", req_cnt, 32'd0);
    tick();
    chk("zero_done_cnt", done_cnt, 32'd1);

    // reset with two reads in flight
    start_run(4, -1);
    begin
      int n = 0;
      while (req_cnt < 2 && n < 50) begin
        tick();
        n++;
      end
    end
    chk("mid_req_cnt", req_cnt, 32'd2);
    read_rdy = 1'b0;
    rst      = 1'b0;
    tick();
    chk("mid_busy",  {31'h0, busy}, 32'd0);
    chk("mid_done",  {31'h0, done}, 32'd0);
    chk("mid_err",   {31'h0, err}, 32'd0);
    chk("mid_rd_en", {31'h0, read_en}, 32'd0);
    chk("mid_rdrdy", {31'h0, read_data_rdy}, 32'd0);
    chk("mid_oval",  {31'h0, out_vld}, 32'd0);
    chk("mid_addr",  {16'h0, read_addr}, 32'd0);
    rst      = 1'b1;
    read_rdy = 1'b1;
    exp_addr.delete();
    exp_out.delete();
    repeat (6) tick();
    chk("late_drained", pend.size(), 32'd0);
    chk("late_err",     {31'h0, err}, 32'd0);
    chk("late_oval",    {31'h0, out_vld}, 32'd0);
    chk("late_busy",    {31'h0, busy}, 32'd0);
    start_run(1, -1);
    wait_done("post_done");
    chk("post_err", {31'h0, err}, 32'd0);
    end_run("post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
